// File: rtl/bram_fifo.sv
// Single-clock FIFO on inferred iCE40 block RAM with registered full/empty/count.
// Define BRAM_FIFO_ERR_EN to build sticky overflow/underflow flags; otherwise they read 0.
module bram_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic                  o_full,
  input  logic                  i_rd_en,
  output logic [WIDTH-1:0]      o_rdata,
  output logic                  o_rvalid,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int AW    = DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_q;
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             wr_acc, rd_acc, seen;

  // Qualification only looks at the registered flags; requests in a reset cycle are dropped.
  assign wr_acc = i_wr_en & ~o_full  & ~i_rst;
  assign rd_acc = i_rd_en & ~o_empty & ~i_rst;
  assign wr_nxt = wr_ptr + PW'(wr_acc);
  assign rd_nxt = rd_ptr + PW'(rd_acc);

  // No reset on the array or its output register so the RAM maps to SB_RAM40_4K.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= i_wdata;
    if (rd_acc) ram_q <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_empty  <= 1'b1;
      o_full   <= 1'b0;
      o_count  <= '0;
      o_rvalid <= 1'b0;
      seen     <= 1'b0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      o_empty  <= (wr_nxt == rd_nxt);
      o_full   <= (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);
      o_count  <= wr_nxt - rd_nxt;
      o_rvalid <= rd_acc;
      seen     <= seen | rd_acc;
    end
  end

  // Uninitialised RAM output is hidden until the first real read after reset.
  assign o_rdata = seen ? ram_q : '0;

`ifdef BRAM_FIFO_ERR_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= o_overflow  | (i_wr_en & o_full);
      o_underflow <= o_underflow | (i_rd_en & o_empty);
    end
  end
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

endmodule
